cp0_regfile: RTL and testbench

Coprocessor-0 register file: the responder side of the writeback stage's CP0 port. It serves `mfc0` reads and `mtc0` writes from WB and records the exception and `eret` state that WB commits. It owns the Count/Compare timer and produces the interrupt-pending and EPC signals consumed by decode/fetch. It sits beside the regfile, clocked with the pipeline; all state changes are driven by WB-committed events.

---
 rtl/cpu_defs.sv | 47 ++++
 rtl/cp0_regfile_if.sv | 15 +
 rtl/cp0_timer.sv | 43 ++++
 rtl/cp0_regfile.sv | 121 ++++++++++++
 tb/tb_cp0_regfile.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: CP0 register addresses, exception codes,
// Status/Cause bit positions and the WB-to-CP0 commit bus.
package cpu_defs;

   // CP0 register addresses as {rd[4:0], sel[2:0]}
   localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
   localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
   localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
   localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
   localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
   localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

   // Exception codes
   localparam logic [4:0] EXCCODE_INT  = 5'h00;
   localparam logic [4:0] EXCCODE_ADEL = 5'h04;
   localparam logic [4:0] EXCCODE_ADES = 5'h05;
   localparam logic [4:0] EXCCODE_SYS  = 5'h08;
   localparam logic [4:0] EXCCODE_BP   = 5'h09;
   localparam logic [4:0] EXCCODE_RI   = 5'h0a;
   localparam logic [4:0] EXCCODE_OV   = 5'h0c;

   // Status / Cause bit positions
   localparam int STATUS_BEV    = 22;
   localparam int STATUS_IM_LO  = 8;
   localparam int STATUS_EXL    = 1;
   localparam int STATUS_IE     = 0;
   localparam int CAUSE_BD      = 31;
   localparam int CAUSE_TI      = 30;
   localparam int CAUSE_IP_LO   = 8;
   localparam int CAUSE_EXC_LO  = 2;

   // Events committed by the writeback stage
   typedef struct packed {
      logic        ex;
      logic [4:0]  exccode;
      logic        bd;
      logic [31:0] pc;
      logic [31:0] badvaddr;
      logic        eret;
   } ws_to_c0_bus_t;

   // Address-error exceptions are the only ones that capture BadVAddr
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXCCODE_ADEL) || (code == EXCCODE_ADES);
   endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// WB <-> CP0 port: mtc0/mfc0 access plus committed exception/eret events.
interface cp0_regfile_if;
   import cpu_defs::*;

   logic          c0_we;
   logic [7:0]    c0_addr;
   logic [31:0]   c0_wdata;
   logic [31:0]   c0_rdata;
   ws_to_c0_bus_t ws;

   modport master (output c0_we, output c0_addr, output c0_wdata, output ws,
                   input  c0_rdata);
   modport slave  (input  c0_we, input  c0_addr, input  c0_wdata, input  ws,
                   output c0_rdata);
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches a match.
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic tick;

   // Half-rate counter; a Count write restarts the tick phase
   always_ff @(posedge clk) begin
      if (reset) begin
         tick  <= 1'b0;
         count <= 32'd0;
      end else if (count_we) begin
         tick  <= 1'b0;
         count <= wdata;
      end else begin
         tick <= ~tick;
         if (tick)
            count <= count + 32'd1;
      end
   end

   // Compare register and timer interrupt; a Compare write beats a match
   always_ff @(posedge clk) begin
      if (reset) begin
         compare <= 32'd0;
         ti      <= 1'b0;
      end else if (compare_we) begin
         compare <= wdata;
         ti      <= 1'b0;
      end else if (count == compare) begin
         ti <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: mfc0/mtc0 access, exception/eret state, interrupt pending.
module cp0_regfile
   import cpu_defs::*;
#(
   parameter logic BEV_RESET = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   cp0_regfile_if.slave       c0,
   input  logic [5:0]         ext_int,
   output logic [31:0]        c0_epc,
   output logic               c0_has_int
);

   ws_to_c0_bus_t ws;
   logic          wr_en;
   logic [31:0]   rdata;

   logic [31:0]   badvaddr;
   logic [7:0]    status_im;
   logic          status_exl;
   logic          status_ie;
   logic          cause_bd;
   logic [1:0]    cause_ip_sw;
   logic [4:0]    cause_exccode;
   logic [31:0]   epc;
   logic [5:0]    ext_int_q;

   logic [31:0]   count;
   logic [31:0]   compare;
   logic          ti;
   logic [7:0]    cause_ip;
   logic [31:0]   status_rd;
   logic [31:0]   cause_rd;

   assign ws = c0.ws;

   // Exceptions and eret take the cycle; a coincident mtc0 is discarded
   assign wr_en = c0.c0_we & ~ws.ex & ~ws.eret;

   cp0_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (wr_en && (c0.c0_addr == CP0_COUNT)),
      .compare_we (wr_en && (c0.c0_addr == CP0_COMPARE)),
      .wdata      (c0.c0_wdata),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   // TI joins IP7 live so the interrupt can follow it by one cycle
   assign cause_ip  = {ext_int_q[5] | ti, ext_int_q[4:0], cause_ip_sw};
   assign status_rd = {9'd0, BEV_RESET, 6'd0, status_im, 6'd0, status_exl, status_ie};
   assign cause_rd  = {cause_bd, ti, 14'd0, cause_ip, 1'b0, cause_exccode, 2'b00};
   assign c0_epc    = epc;

   // Architectural state update: exception > eret > mtc0
   always_ff @(posedge clk) begin
      if (reset) begin
         badvaddr      <= 32'd0;
         status_im     <= 8'd0;
         status_exl    <= 1'b0;
         status_ie     <= 1'b0;
         cause_bd      <= 1'b0;
         cause_ip_sw   <= 2'd0;
         cause_exccode <= 5'd0;
         epc           <= 32'd0;
      end else if (ws.ex) begin
         status_exl    <= 1'b1;
         cause_exccode <= ws.exccode;
         if (!status_exl) begin
            epc      <= ws.bd ? (ws.pc - 32'd4) : ws.pc;
            cause_bd <= ws.bd;
         end
         if (is_addr_exc(ws.exccode))
            badvaddr <= ws.badvaddr;
      end else if (ws.eret) begin
         status_exl <= 1'b0;
      end else if (wr_en) begin
         case (c0.c0_addr)
            CP0_STATUS: begin
               status_im  <= c0.c0_wdata[STATUS_IM_LO +: 8];
               status_exl <= c0.c0_wdata[STATUS_EXL];
               status_ie  <= c0.c0_wdata[STATUS_IE];
            end
            CP0_CAUSE: cause_ip_sw <= c0.c0_wdata[CAUSE_IP_LO +: 2];
            CP0_EPC:   epc         <= c0.c0_wdata;
            default: ;
         endcase
      end
   end

   // Sample hardware interrupt lines and register the pending indication
   always_ff @(posedge clk) begin
      if (reset) begin
         ext_int_q  <= 6'd0;
         c0_has_int <= 1'b0;
      end else begin
         ext_int_q  <= ext_int;
         c0_has_int <= (|(cause_ip & status_im)) & status_ie & ~status_exl;
      end
   end

   // Combinational mfc0 read; unmapped addresses read zero
   always_comb begin
      rdata = 32'd0;
      case (c0.c0_addr)
         CP0_BADVADDR: rdata = badvaddr;
         CP0_COUNT:    rdata = count;
         CP0_COMPARE:  rdata = compare;
         CP0_STATUS:   rdata = status_rd;
         CP0_CAUSE:    rdata = cause_rd;
         CP0_EPC:      rdata = epc;
         default:      rdata = 32'd0;
      endcase
   end

   assign c0.c0_rdata = rdata;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expected register reads are queued as
// stimulus is applied and compared once the DUT has updated.
module tb_cp0_regfile;
   import cpu_defs::*;

   logic        clk;
   logic        reset;
   logic [5:0]  ext_int;
   logic [31:0] c0_epc;
   logic        c0_has_int;

   cp0_regfile_if bus ();

   cp0_regfile #(.BEV_RESET(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .c0         (bus),
      .ext_int    (ext_int),
      .c0_epc     (c0_epc),
      .c0_has_int (c0_has_int)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   string       tag_q[$];
   logic [7:0]  addr_q[$];
   logic [31:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input string tag, input logic [7:0] addr, input logic [31:0] val);
      tag_q.push_back(tag);
      addr_q.push_back(addr);
      exp_q.push_back(val);
   endtask

   // Read back every queued register (kept short so it fits in one cycle)
   task automatic drain();
      while (exp_q.size() > 0) begin
         string       t;
         logic [7:0]  a;
         logic [31:0] e;
         t = tag_q.pop_front();
         a = addr_q.pop_front();
         e = exp_q.pop_front();
         bus.c0_addr = a;
         #1;
         check_eq(t, bus.c0_rdata, e);
      end
   endtask

   task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
      bus.c0_we    = 1'b1;
      bus.c0_addr  = addr;
      bus.c0_wdata = data;
      cycle();
      bus.c0_we    = 1'b0;
   endtask

   task automatic ws_exc(input logic [4:0] code, input logic bd,
                         input logic [31:0] pc, input logic [31:0] bva);
      bus.ws.ex       = 1'b1;
      bus.ws.exccode  = code;
      bus.ws.bd       = bd;
      bus.ws.pc       = pc;
      bus.ws.badvaddr = bva;
      cycle();
      bus.ws.ex       = 1'b0;
   endtask

   task automatic ws_eret();
      bus.ws.eret = 1'b1;
      cycle();
      bus.ws.eret = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      ext_int      = 6'd0;
      bus.c0_we    = 1'b0;
      bus.c0_addr  = 8'd0;
      bus.c0_wdata = 32'd0;
      bus.ws       = '0;

      // Reset values, read while reset is still held
      repeat (3) cycle();
      exp_push("rst_status",   CP0_STATUS,   32'h0040_0000);
      exp_push("rst_cause",    CP0_CAUSE,    32'h0000_0000);
      exp_push("rst_epc",      CP0_EPC,      32'h0000_0000);
      exp_push("rst_count",    CP0_COUNT,    32'h0000_0000);
      exp_push("rst_badvaddr", CP0_BADVADDR, 32'h0000_0000);
      drain();
      check_eq("rst_has_int", {31'd0, c0_has_int}, 32'd0);
      check_eq("rst_c0_epc", c0_epc, 32'd0);
      reset = 1'b0;

      // Park the timer far from a match and clear the reset-time TI
      mtc0(CP0_COUNT, 32'h0000_1000);
      exp_push("count_wr", CP0_COUNT, 32'h0000_1000);
      drain();
      mtc0(CP0_COMPARE, 32'hFFFF_0000);
      exp_push("compare_wr", CP0_COMPARE, 32'hFFFF_0000);
      drain();

      // Write masks of Status/Cause, and no same-cycle bypass
      bus.c0_we    = 1'b1;
      bus.c0_addr  = CP0_STATUS;
      bus.c0_wdata = 32'hFFFF_FFFF;
      #1;
      check_eq("status_no_bypass", bus.c0_rdata, 32'h0040_0000);
      cycle();
      bus.c0_we = 1'b0;
      exp_push("status_mask", CP0_STATUS, 32'h0040_FF03);
      drain();
      mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
      exp_push("cause_mask", CP0_CAUSE, 32'h0000_0300);
      drain();
      mtc0(CP0_CAUSE, 32'h0);
      mtc0(CP0_STATUS, 32'h0);
      exp_push("unmapped_sel1", 8'h61, 32'h0);
      drain();

      // Timer: Compare=10, Count=0 -> TI at cycle 21, interrupt at 22
      mtc0(CP0_STATUS, 32'h0000_8001);
      mtc0(CP0_COMPARE, 32'd10);
      mtc0(CP0_COUNT, 32'd0);
      for (int k = 1; k <= 22; k++) begin
         cycle();
         if (k == 20) begin
            bus.c0_addr = CP0_COUNT;
            #1;
            check_eq("count_at_20", bus.c0_rdata, 32'd10);
            bus.c0_addr = CP0_CAUSE;
            #1;
            check_eq("ti_at_20", {31'd0, bus.c0_rdata[CAUSE_TI]}, 32'd0);
         end
         if (k == 21) begin
            bus.c0_addr = CP0_CAUSE;
            #1;
            check_eq("ti_at_21", {31'd0, bus.c0_rdata[CAUSE_TI]}, 32'd1);
            check_eq("has_int_at_21", {31'd0, c0_has_int}, 32'd0);
         end
         if (k == 22)
            check_eq("has_int_at_22", {31'd0, c0_has_int}, 32'd1);
      end
      mtc0(CP0_COMPARE, 32'hFFFF_0000);
      exp_push("ti_cleared", CP0_CAUSE, 32'h0000_0000);
      drain();
      cycle();
      check_eq("has_int_after_clr", {31'd0, c0_has_int}, 32'd0);
      mtc0(CP0_STATUS, 32'h0);

      // Address error in a delay slot, then a nested exception, then eret
      ws_exc(EXCCODE_ADEL, 1'b1, 32'hBFC0_0104, 32'h1234_5671);
      exp_push("ex_epc",      CP0_EPC,      32'hBFC0_0100);
      exp_push("ex_cause",    CP0_CAUSE,    32'h8000_0010);
      exp_push("ex_badvaddr", CP0_BADVADDR, 32'h1234_5671);
      exp_push("ex_status",   CP0_STATUS,   32'h0040_0002);
      drain();
      check_eq("ex_c0_epc", c0_epc, 32'hBFC0_0100);
      ws_exc(EXCCODE_OV, 1'b0, 32'h8000_0000, 32'hAAAA_AAAA);
      exp_push("ex2_epc_hold",  CP0_EPC,      32'hBFC0_0100);
      exp_push("ex2_cause",     CP0_CAUSE,    32'h8000_0030);
      exp_push("ex2_bva_hold",  CP0_BADVADDR, 32'h1234_5671);
      drain();
      ws_eret();
      exp_push("eret_status", CP0_STATUS, 32'h0040_0000);
      drain();

      // mtc0 colliding with an exception, then with an eret
      bus.c0_we    = 1'b1;
      bus.c0_addr  = CP0_EPC;
      bus.c0_wdata = 32'hDEAD_BEEF;
      ws_exc(EXCCODE_SYS, 1'b0, 32'h8000_1000, 32'h0);
      bus.c0_we = 1'b0;
      exp_push("we_vs_ex_epc", CP0_EPC,   32'h8000_1000);
      exp_push("we_vs_ex_cause", CP0_CAUSE, 32'h0000_0020);
      drain();
      bus.c0_we    = 1'b1;
      bus.c0_addr  = CP0_STATUS;
      bus.c0_wdata = 32'h0000_FF01;
      ws_eret();
      bus.c0_we = 1'b0;
      exp_push("we_vs_eret", CP0_STATUS, 32'h0040_0000);
      drain();

      // Hardware interrupt line 1 through IM[11], masked once EXL is set
      ext_int = 6'b000010;
      mtc0(CP0_STATUS, 32'h0000_0801);
      cycle();
      check_eq("ext_int_pending", {31'd0, c0_has_int}, 32'd1);
      exp_push("ext_int_cause", CP0_CAUSE, 32'h0000_0820);
      drain();
      ws_exc(EXCCODE_INT, 1'b0, 32'h8000_2000, 32'h0);
      cycle();
      check_eq("int_masked_exl", {31'd0, c0_has_int}, 32'd0);

      // Count wraps to zero after its second cycle at 0xFFFF_FFFF
      mtc0(CP0_COUNT, 32'hFFFF_FFFF);
      exp_push("wrap_0", CP0_COUNT, 32'hFFFF_FFFF);
      drain();
      cycle();
      exp_push("wrap_1", CP0_COUNT, 32'hFFFF_FFFF);
      drain();
      cycle();
      exp_push("wrap_2", CP0_COUNT, 32'h0000_0000);
      drain();

      // Reset in the middle of activity
      ext_int = 6'd0;
      reset   = 1'b1;
      cycle();
      exp_push("mrst_status",   CP0_STATUS,   32'h0040_0000);
      exp_push("mrst_cause",    CP0_CAUSE,    32'h0000_0000);
      exp_push("mrst_epc",      CP0_EPC,      32'h0000_0000);
      exp_push("mrst_badvaddr", CP0_BADVADDR, 32'h0000_0000);
      exp_push("mrst_count",    CP0_COUNT,    32'h0000_0000);
      exp_push("mrst_compare",  CP0_COMPARE,  32'h0000_0000);
      drain();
      check_eq("mrst_has_int", {31'd0, c0_has_int}, 32'd0);
      check_eq("mrst_c0_epc", c0_epc, 32'd0);
      reset = 1'b0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
